// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO bus sequencer.
package mmio_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 8;

  localparam logic [ADDR_W-1:0] MMIO_BASE = 32'hFFFF_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FAULT_NONE      = 2'd0,
    FAULT_UNCLAIMED = 2'd1,
    FAULT_MULTI     = 2'd2,
    FAULT_TIMEOUT   = 2'd3
  } fault_e;

  // One latched CPU access as presented on the shared bus.
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mmio_req_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/mmio_bus_ctrl_if.sv
// CPU-side handshake plus shared MMIO bus; master = sequencer, slave = CPU and peripherals.
interface mmio_bus_ctrl_if #(
  parameter int unsigned N_SLAVES = 4
) ();
  import mmio_pkg::*;

  logic                       cpu_read;
  logic                       cpu_write;
  logic [ADDR_W-1:0]          cpu_addr;
  logic [DATA_W-1:0]          cpu_wdata;
  logic                       cpu_ready;
  logic [DATA_W-1:0]          cpu_rdata;
  logic                       cpu_fault;
  logic [1:0]                 fault_cause;
  logic [ADDR_W-1:0]          fault_addr;
  logic [CNT_W-1:0]           err_count;

  logic                       mmio_read;
  logic                       mmio_write;
  logic [ADDR_W-1:0]          mmio_addr;
  logic [DATA_W-1:0]          mmio_write_data;
  logic [N_SLAVES-1:0]        slv_work;
  logic [N_SLAVES-1:0]        slv_done;
  logic [DATA_W*N_SLAVES-1:0] slv_rdata;

  modport master (
    input  cpu_read, cpu_write, cpu_addr, cpu_wdata,
    input  slv_work, slv_done, slv_rdata,
    output cpu_ready, cpu_rdata, cpu_fault, fault_cause, fault_addr, err_count,
    output mmio_read, mmio_write, mmio_addr, mmio_write_data
  );

  modport slave (
    output cpu_read, cpu_write, cpu_addr, cpu_wdata,
    output slv_work, slv_done, slv_rdata,
    input  cpu_ready, cpu_rdata, cpu_fault, fault_cause, fault_addr, err_count,
    input  mmio_read, mmio_write, mmio_addr, mmio_write_data
  );

endinterface

// File: rtl/mmio_claim_check.sv
// Classifies the slave claim vector: none, exactly one, and the index of the lowest claimant.
module mmio_claim_check #(
  parameter int unsigned N_SLAVES = 4,
  parameter int unsigned IDX_W    = 2
) (
  input  logic [N_SLAVES-1:0] work,
  output logic                one_hot,
  output logic                none,
  output logic [IDX_W-1:0]    idx
);

  always_comb begin
    none    = (work == '0);
    one_hot = !none && ((work & (work - N_SLAVES'(1))) == '0);
    idx     = '0;
    for (int i = int'(N_SLAVES) - 1; i >= 0; i--) begin
      if (work[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/mmio_bus_ctrl.sv
// Single-master MMIO sequencer: latches a CPU access, runs it on the shared bus and
// turns unclaimed, multi-claimed, illegal or hung accesses into a reported fault.
module mmio_bus_ctrl
  import mmio_pkg::*;
#(
  parameter int unsigned N_SLAVES = 4,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic            sys_clk,
  input  logic            rst_n,
  mmio_bus_ctrl_if.master bus
);

  localparam int unsigned      IDX_W      = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  mmio_req_t         req_q, req_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic              ready_q, ready_d;
  logic              fault_q, fault_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  fault_e            cause_q, cause_d;
  logic [ADDR_W-1:0] faddr_q, faddr_d;
  logic [CNT_W-1:0]  err_q, err_d;

  logic              claim_one, claim_none;
  logic [IDX_W-1:0]  claim_idx;
  logic              done_sel;
  logic [DATA_W-1:0] rdata_sel;
  logic              finish, fail;
  fault_e            fail_cause;
  logic [ADDR_W-1:0] fail_addr;

  mmio_claim_check #(
    .N_SLAVES (N_SLAVES),
    .IDX_W    (IDX_W)
  ) u_claim (
    .work    (bus.slv_work),
    .one_hot (claim_one),
    .none    (claim_none),
    .idx     (claim_idx)
  );

  // Done and read data of the slave that claimed the access; others are ignored.
  always_comb begin
    done_sel  = 1'b0;
    rdata_sel = '0;
    for (int i = 0; i < int'(N_SLAVES); i++) begin
      if (idx_q == IDX_W'(i)) begin
        done_sel  = bus.slv_done[i];
        rdata_sel = bus.slv_rdata[DATA_W*i +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    idx_d      = idx_q;
    req_d      = req_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    ready_d    = 1'b0;
    fault_d    = 1'b0;
    rdata_d    = '0;
    cause_d    = cause_q;
    faddr_d    = faddr_q;
    err_d      = err_q;
    finish     = 1'b0;
    fail       = 1'b0;
    fail_cause = FAULT_NONE;
    fail_addr  = req_q.addr;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.cpu_read ^ bus.cpu_write) begin
          req_d   = '{write: bus.cpu_write, addr: bus.cpu_addr, wdata: bus.cpu_wdata};
          rd_d    = bus.cpu_read;
          wr_d    = bus.cpu_write;
          timer_d = '0;
          state_d = ST_BUSY;
        end else if (bus.cpu_read && bus.cpu_write) begin
          finish     = 1'b1;
          fail       = 1'b1;
          fail_cause = FAULT_TIMEOUT;
          fail_addr  = bus.cpu_addr;
        end
      end
      ST_BUSY: begin
        timer_d = timer_q + CNT_W'(1);
        if (timer_q == '0) idx_d = claim_idx;
        // The claim is only judged in the first cycle the strobe is visible.
        if (timer_q == '0 && claim_none) begin
          finish     = 1'b1;
          fail       = 1'b1;
          fail_cause = FAULT_UNCLAIMED;
        end else if (timer_q == '0 && !claim_one) begin
          finish     = 1'b1;
          fail       = 1'b1;
          fail_cause = FAULT_MULTI;
        end else if (timer_q != '0 && done_sel) begin
          finish  = 1'b1;
          rdata_d = req_q.write ? '0 : rdata_sel;
        end else if (timer_q == TIMER_LAST) begin
          finish     = 1'b1;
          fail       = 1'b1;
          fail_cause = FAULT_TIMEOUT;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Strobes drop on the same edge that enters RESP so a slave never sees a repeat request.
    if (finish) begin
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      ready_d = 1'b1;
      state_d = ST_RESP;
    end
    if (fail) begin
      fault_d = 1'b1;
      cause_d = fail_cause;
      faddr_d = fail_addr;
      err_d   = sat_inc(err_q);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      req_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= '0;
      cause_q <= FAULT_NONE;
      faddr_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      req_q   <= req_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
      cause_q <= cause_d;
      faddr_q <= faddr_d;
      err_q   <= err_d;
    end
  end

  assign bus.cpu_ready       = ready_q;
  assign bus.cpu_rdata       = rdata_q;
  assign bus.cpu_fault       = fault_q;
  assign bus.fault_cause     = cause_q;
  assign bus.fault_addr      = faddr_q;
  assign bus.err_count       = err_q;
  assign bus.mmio_read       = rd_q;
  assign bus.mmio_write      = wr_q;
  assign bus.mmio_addr       = req_q.addr;
  assign bus.mmio_write_data = req_q.wdata;

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Random and directed accesses against four slave models, checked every cycle
// against a transaction-level reference of latency, result and fault bookkeeping.
module tb_mmio_bus_ctrl;
  import mmio_pkg::*;

  localparam int unsigned NS = 4;
  localparam int unsigned TO = 8;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;

  mmio_bus_ctrl_if #(.N_SLAVES(NS)) bus ();

  mmio_bus_ctrl #(.N_SLAVES(NS), .TIMEOUT(TO)) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Slave decode: 0 LED @0x80, 1 switches @0x00, 2 also claims base word + own @0x100, 3 hung @0x200.
  function automatic bit claims(input int i, input logic [31:0] a);
    case (i)
      0: return a[31:4] == 28'hFFFF008;
      1: return a[31:4] == 28'hFFFF000;
      2: return (a == MMIO_BASE) || (a[31:4] == 28'hFFFF010);
      3: return a[31:4] == 28'hFFFF020;
      default: return 1'b0;
    endcase
  endfunction

  logic [31:0]   smem [3][4];
  logic [NS-1:0] sdone;

  always_comb begin
    for (int i = 0; i < int'(NS); i++)
      bus.slv_work[i] = (bus.mmio_read | bus.mmio_write) && claims(i, bus.mmio_addr);
  end

  always_comb begin
    for (int i = 0; i < 3; i++) bus.slv_rdata[32*i +: 32] = smem[i][bus.mmio_addr[3:2]];
    bus.slv_rdata[96 +: 32] = 32'hDEAD_0003;
  end

  assign bus.slv_done = sdone;

  // Slaves answer one cycle after claiming; slave 3 never answers.
  always @(posedge sys_clk) begin
    if (!rst_n) begin
      sdone <= '0;
      for (int i = 0; i < 3; i++)
        for (int w = 0; w < 4; w++) smem[i][w] <= '0;
    end else begin
      sdone <= bus.slv_work & ~sdone & 4'b0111;
      for (int i = 0; i < 3; i++)
        if (sdone[i] && bus.mmio_write) smem[i][bus.mmio_addr[3:2]] <= bus.mmio_write_data;
    end
  end

  // Reference model state.
  logic [31:0] mm [3][4];
  int          k_start = -100;
  int          e_lat = 0;
  bit          e_rd, e_wr, e_fault;
  logic [1:0]  e_cause;
  logic [31:0] e_rdata, e_addr, e_wdata;
  logic [1:0]  m_cause;
  logic [31:0] m_faddr;
  int          m_err;
  bit          mdl_on = 1'b0;

  int          got_lat;
  logic [31:0] got_rdata, got_faddr;
  logic        got_fault;
  logic [1:0]  got_cause;
  logic [7:0]  got_err;

  int   wr_rise = 0;
  logic prev_wr = 1'b0;
  always @(negedge sys_clk) begin
    if (bus.mmio_write && !prev_wr) wr_rise++;
    prev_wr = bus.mmio_write;
  end

  always @(negedge sys_clk) begin : cmp
    bit rdy, busy;
    if (mdl_on) begin
      rdy  = (cyc == k_start + e_lat - 1);
      busy = (cyc >= k_start + 1) && (cyc <= k_start + e_lat - 2);
      if (rdy && e_fault) begin
        m_cause = e_cause;
        m_faddr = e_addr;
        if (m_err < 255) m_err++;
      end
      chk("cpu_ready",   32'(bus.cpu_ready),   32'(rdy));
      chk("cpu_rdata",   bus.cpu_rdata,        rdy ? e_rdata : 32'd0);
      chk("cpu_fault",   32'(bus.cpu_fault),   32'(rdy && e_fault));
      chk("fault_cause", 32'(bus.fault_cause), 32'(m_cause));
      chk("fault_addr",  bus.fault_addr,       m_faddr);
      chk("err_count",   32'(bus.err_count),   32'(m_err));
      chk("mmio_read",   32'(bus.mmio_read),   32'(busy && e_rd && !e_wr));
      chk("mmio_write",  32'(bus.mmio_write),  32'(busy && e_wr && !e_rd));
      if (busy && (e_rd ^ e_wr)) chk("mmio_addr", bus.mmio_addr, e_addr);
      if (busy && e_wr && !e_rd) chk("mmio_write_data", bus.mmio_write_data, e_wdata);
    end
  end

  task automatic clear_model();
    for (int i = 0; i < 3; i++)
      for (int w = 0; w < 4; w++) mm[i][w] = '0;
    m_cause = '0;
    m_faddr = '0;
    m_err   = 0;
    k_start = -100;
    e_lat   = 0;
  endtask

  // Called just after a rising edge with the controller idle; returns just after a rising edge.
  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd);
    int cnt = 0;
    int j = 0;
    e_fault = 1'b1;
    e_rdata = '0;
    if (rd && wr) begin
      e_lat = 2; e_cause = 2'd3;
    end else begin
      for (int i = 0; i < int'(NS); i++)
        if (claims(i, a)) begin cnt++; j = i; end
      if (cnt == 0)      begin e_lat = 3;      e_cause = 2'd1; end
      else if (cnt > 1)  begin e_lat = 3;      e_cause = 2'd2; end
      else if (j == 3)   begin e_lat = TO + 2; e_cause = 2'd3; end
      else begin
        e_lat = 4; e_cause = 2'd0; e_fault = 1'b0;
        if (rd) e_rdata = mm[j][a[3:2]];
        if (wr) mm[j][a[3:2]] = wd;
      end
    end
    e_rd = rd; e_wr = wr; e_addr = a; e_wdata = wd;
    k_start = cyc;
    bus.cpu_read  = rd;
    bus.cpu_write = wr;
    bus.cpu_addr  = a;
    bus.cpu_wdata = wd;
    got_lat = 0;
    for (int n = 1; n <= e_lat + 4 && got_lat == 0; n++) begin
      @(negedge sys_clk);
      if (bus.cpu_ready) begin
        got_lat   = cyc - k_start + 1;
        got_rdata = bus.cpu_rdata;
        got_fault = bus.cpu_fault;
        got_cause = bus.fault_cause;
        got_faddr = bus.fault_addr;
        got_err   = bus.err_count;
      end
    end
    if (got_lat == 0) begin
      failures++;
      checks++;
      $display("FAIL ready_timeout at cycle %0d: no cpu_ready within %0d cycles", cyc, e_lat + 4);
    end
    @(posedge sys_clk);
    #1;
    bus.cpu_read  = 1'b0;
    bus.cpu_write = 1'b0;
    bus.cpu_addr  = $urandom;
    bus.cpu_wdata = $urandom;
  endtask

  initial begin
    int w0;
    int r, u;
    logic [31:0] a;
    bus.cpu_read  = 1'b0;
    bus.cpu_write = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    clear_model();
    rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    rst_n  = 1'b1;
    mdl_on = 1'b1;

    @(negedge sys_clk);
    chk("rst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
    chk("rst_err_count", 32'(bus.err_count), 32'd0);
    chk("rst_mmio_read", 32'(bus.mmio_read), 32'd0);
    @(posedge sys_clk);
    #1;

    // LED write then read back.
    w0 = wr_rise;
    access(1'b0, 1'b1, 32'hFFFF0084, 32'd1);
    chk("led_wr_bursts", 32'(wr_rise - w0), 32'd1);
    chk("led_wr_lat",    32'(got_lat), 32'd4);
    chk("led_wr_fault",  32'(got_fault), 32'd0);
    access(1'b1, 1'b0, 32'hFFFF0084, 32'd0);
    chk("led_rd_data",   got_rdata, 32'd1);
    chk("led_rd_lat",    32'(got_lat), 32'd4);
    chk("led_rd_fault",  32'(got_fault), 32'd0);

    access(1'b1, 1'b0, 32'hFFFF1000, 32'd0);
    chk("unclaimed_lat",   32'(got_lat), 32'd3);
    chk("unclaimed_fault", 32'(got_fault), 32'd1);
    chk("unclaimed_cause", 32'(got_cause), 32'd1);
    chk("unclaimed_addr",  got_faddr, 32'hFFFF1000);
    chk("unclaimed_err",   32'(got_err), 32'd1);

    access(1'b1, 1'b0, MMIO_BASE, 32'd0);
    chk("multi_lat",   32'(got_lat), 32'd3);
    chk("multi_cause", 32'(got_cause), 32'd2);
    chk("multi_rdata", got_rdata, 32'd0);
    chk("multi_err",   32'(got_err), 32'd2);

    access(1'b1, 1'b0, 32'hFFFF0200, 32'd0);
    chk("hung_lat",   32'(got_lat), 32'd10);
    chk("hung_cause", 32'(got_cause), 32'd3);
    chk("hung_err",   32'(got_err), 32'd3);

    w0 = wr_rise;
    access(1'b1, 1'b1, 32'hFFFF0010, 32'h1234);
    chk("illegal_lat",   32'(got_lat), 32'd2);
    chk("illegal_cause", 32'(got_cause), 32'd3);
    chk("illegal_addr",  got_faddr, 32'hFFFF0010);
    chk("illegal_nowr",  32'(wr_rise - w0), 32'd0);
    chk("mdl_err_pin",   32'(m_err), 32'd4);

    for (int t = 0; t < 150; t++) begin
      r = $urandom_range(0, 9);
      u = $urandom_range(0, 5);
      case (u)
        0: a = 32'hFFFF0080 + 32'(4 * $urandom_range(0, 3));
        1: a = MMIO_BASE    + 32'(4 * $urandom_range(0, 3));
        2: a = 32'hFFFF0100 + 32'(4 * $urandom_range(0, 3));
        3: a = 32'hFFFF0200;
        4: a = 32'hFFFF1000 + 32'(4 * $urandom_range(0, 15));
        default: a = $urandom & 32'hFFFF_FFFC;
      endcase
      access(r < 1 || r >= 5, r < 5, a, $urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge sys_clk);
        #1;
      end
    end

    for (int t = 0; t < 256; t++) access(1'b1, 1'b1, $urandom, 32'd0);
    chk("err_saturated", 32'(got_err), 32'd255);
    chk("mdl_err_sat",   32'(m_err), 32'd255);

    // Reset in the middle of a hung access.
    mdl_on = 1'b0;
    bus.cpu_read = 1'b1;
    bus.cpu_addr = 32'hFFFF0200;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("busy_strobe", 32'(bus.mmio_read), 32'd1);
    rst_n = 1'b0;
    bus.cpu_read = 1'b0;
    @(posedge sys_clk);
    #1;
    chk("rst_busy_read",  32'(bus.mmio_read), 32'd0);
    chk("rst_busy_ready", 32'(bus.cpu_ready), 32'd0);
    chk("rst_busy_err",   32'(bus.err_count), 32'd0);
    chk("rst_busy_cause", 32'(bus.fault_cause), 32'd0);
    rst_n = 1'b1;
    clear_model();
    mdl_on = 1'b1;

    access(1'b0, 1'b1, 32'hFFFF0088, 32'hCAFEF00D);
    access(1'b1, 1'b0, 32'hFFFF0088, 32'd0);
    chk("post_rst_rdata", got_rdata, 32'hCAFEF00D);
    chk("post_rst_lat",   32'(got_lat), 32'd4);
    chk("post_rst_fault", 32'(got_fault), 32'd0);

    repeat (2) @(posedge sys_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmio_bus_ctrl.md
Name: mmio_bus_ctrl

Overview:
- Single-master MMIO sequencer between the CPU memory stage and the 0xFFFF_xxxx peripheral slaves (LEDs, switches, segment display, UART, and similar).
- Latches one CPU access and drives the shared mmio_read/mmio_write/mmio_addr/mmio_write_data bus.
- Collects each slave's mmio_work claim and mmio_done pulse, muxes read data back, and returns a one-cycle ready pulse to the CPU.
- Converts unclaimed, multiply-claimed, illegal and hung accesses into a reported fault instead of a stalled pipeline.

Parameters:
- N_SLAVES, 4, number of attached MMIO slaves (1..8).
- TIMEOUT, 255, maximum BUSY cycles waiting for mmio_done before a timeout fault (1..255).

Ports:
- sys_clk  in  1  clock.
- rst_n  in  1  reset: synchronous, active-low; clock sys_clk.
- cpu_read  in  1  read request; level, held until cpu_ready.
- cpu_write  in  1  write request; level, held until cpu_ready.
- cpu_addr  in  32  access address.
- cpu_wdata  in  32  write data.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_rdata  out  32  read data; valid only with cpu_ready, otherwise 0.
- cpu_fault  out  1  asserted with cpu_ready when the access failed.
- fault_cause  out  2  cause code: 0 none, 1 unclaimed, 2 multi-claim, 3 timeout or illegal; holds the last fault.
- fault_addr  out  32  address of the last faulting access.
- err_count  out  8  saturating fault counter.
- mmio_read  out  1  shared bus read strobe (registered).
- mmio_write  out  1  shared bus write strobe (registered).
- mmio_addr  out  32  shared bus address (registered).
- mmio_write_data  out  32  shared bus write data (registered).
- slv_work  in  N_SLAVES  per-slave claim; combinational from the bus.
- slv_done  in  N_SLAVES  per-slave done; arrives 1 cycle after the claim and lasts 1 cycle.
- slv_rdata  in  32*N_SLAVES  per-slave read data; slave i occupies bits [32i+31:32i].

Behaviour:
- Reset (rst_n=0 at a sys_clk edge):
  - All outputs go to 0, FSM goes to IDLE, timer clears, err_count clears.
  - Reset mid-access aborts the access with no cpu_ready; the bus strobes drop on the same edge.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - cpu_read XOR cpu_write: latch addr, wdata and op. Next cycle drive mmio_addr/mmio_write_data and assert exactly one strobe. Timer=0. Go to BUSY.
  - cpu_read AND cpu_write: no bus activity. Go to RESP with fault, cause 3, fault_addr=cpu_addr.
- BUSY, first cycle (strobe visible to slaves):
  - slv_work==0: drop strobe, cause 1, go to RESP.
  - More than one slv_work bit set: drop strobe, cause 2, go to RESP.
  - Otherwise record the claiming index.
- BUSY, any cycle:
  - slv_done of the claimed slave set: capture that slave's slv_rdata (0 for writes), drop the strobe on the next edge, go to RESP.
  - Strobe must be low the cycle after done is seen. This prevents re-triggering, because slaves re-assert done if the request persists.
  - slv_done from a non-claimed slave is ignored.
- Timeout: the timer increments each BUSY cycle. timer==TIMEOUT without done: drop strobe, cause 3, go to RESP.
- RESP:
  - cpu_ready=1 for exactly one cycle, with cpu_rdata and cpu_fault.
  - On a fault: fault_cause and fault_addr update; err_count increments, saturating at 255.
  - On success: fault_cause and err_count are unchanged.
  - Next state is IDLE.
- CPU requests are ignored in BUSY/RESP. The CPU deasserts its request in the cycle after cpu_ready; a still-held request in IDLE starts a new access.
- Minimum latency, request to cpu_ready: 4 cycles (IDLE latch, BUSY claim, BUSY done, RESP).
- Back-to-back accesses: bus strobes stay low for at least 2 cycles between accesses, so slave done fully clears.
- Only 4-byte accesses. Address decode belongs to the slaves; this block does no decode.

Decomposition:
- Package mmio_pkg: FSM state encoding, fault cause codes (FAULT_NONE/UNCLAIMED/MULTI/TIMEOUT), MMIO base 32'hFFFF0000.
- One sub-module: mmio_claim_check. Combinational; takes slv_work and returns a one-hot-valid flag, a zero flag and the binary index. Used for the claim check and the rdata mux select.

Test Plan:
- Slave model 1 (LED-style, base 0xFFFF0080). Write 0xFFFF0084 data 1, then read it back -> two cpu_ready pulses, cpu_rdata=1, cpu_fault=0, exactly one mmio_write cycle with the strobe low after done.
- Read 0xFFFF1000, unclaimed -> cpu_ready at cycle 3 (IDLE latch, BUSY claim, RESP), cpu_fault=1, fault_cause=1, fault_addr=0xFFFF1000, err_count=1.
- Two slave models both claim 0xFFFF0000 -> fault_cause=2, no cpu_rdata (0), strobe dropped after 1 BUSY cycle.
- Slave claims but never asserts done, with TIMEOUT=8 -> cpu_ready 8 BUSY cycles after the claim, fault_cause=3.
- cpu_read=cpu_write=1 -> no mmio strobe ever asserted, fault_cause=3. After 256 such faults err_count=255 (saturated).
- Assert rst_n=0 while in BUSY -> next edge: mmio_read=0, cpu_ready=0, err_count=0. A following normal read completes correctly.
